// File: rtl/fir_serial_mac.sv
// Time-multiplexed direct-form FIR: one signed multiplier, one accumulator, TAPS+1 cycles per sample.
// Optional output saturation and sat_flag port when FIR_SAT_EN is defined; otherwise the output wraps.
module fir_serial_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 21,
    parameter int OUT_W  = 18,
    localparam int AW    = $clog2(TAPS),
    localparam int PW    = DATA_W + COEF_W,
    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  y,
`ifdef FIR_SAT_EN
    output logic                     sat_flag,
`endif
    output logic                     busy
);

    typedef enum logic {IDLE, MAC} state_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             k_q, k_d;
    logic [AW-1:0]             wp_q, wp_d;
    logic [AW-1:0]             base_q, base_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [OUT_W-1:0]   y_q, y_d;
    logic                      ov_q, ov_d;
    logic signed [COEF_W-1:0]  coef_q [TAPS];
    logic signed [COEF_W-1:0]  coef_d [TAPS];
    logic signed [DATA_W-1:0]  hist_q [TAPS];
    logic signed [DATA_W-1:0]  hist_d [TAPS];

    logic [AW:0]               rd_sum;
    logic [AW-1:0]             rd_idx;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   acc_fin;
    logic signed [OUT_W-1:0]   y_red;

    // Tap k reads (base - k) mod TAPS; adding TAPS first keeps the subtraction non-negative.
    always_comb begin
        rd_sum = {1'b0, base_q} + (AW+1)'(TAPS) - {1'b0, k_q};
        rd_idx = (rd_sum >= (AW+1)'(TAPS)) ? AW'(rd_sum - (AW+1)'(TAPS)) : AW'(rd_sum);
    end

    assign prod    = coef_q[k_q] * hist_q[rd_idx];
    assign acc_fin = acc_q + ACC_W'(prod);

`ifdef FIR_SAT_EN
    logic sat_now, sat_q, sat_d;
`endif

    generate
        if (OUT_W >= ACC_W) begin : g_ext
            assign y_red = OUT_W'(acc_fin);
`ifdef FIR_SAT_EN
            assign sat_now = 1'b0;
`endif
        end else begin : g_red
`ifdef FIR_SAT_EN
            localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
            always_comb begin
                sat_now = 1'b1;
                if (acc_fin > SAT_MAX)      y_red = SAT_MAX[OUT_W-1:0];
                else if (acc_fin < SAT_MIN) y_red = SAT_MIN[OUT_W-1:0];
                else begin
                    y_red   = acc_fin[OUT_W-1:0];
                    sat_now = 1'b0;
                end
            end
`else
            assign y_red = acc_fin[OUT_W-1:0];
`endif
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wp_d    = wp_q;
        base_d  = base_q;
        acc_d   = acc_q;
        y_d     = y_q;
        ov_d    = 1'b0;
        coef_d  = coef_q;
        hist_d  = hist_q;
`ifdef FIR_SAT_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            IDLE: begin
                // Coefficient write lands in the same edge as an accepted sample, so it applies to it.
                if (coef_we && (int'(coef_addr) < TAPS))
                    coef_d[coef_addr] = coef_data;
                if (in_valid) begin
                    hist_d[wp_q] = x;
                    base_d       = wp_q;
                    wp_d         = (wp_q == AW'(TAPS-1)) ? '0 : wp_q + AW'(1);
                    acc_d        = '0;
                    k_d          = '0;
                    state_d      = MAC;
                end
            end
            MAC: begin
                acc_d = acc_fin;
                k_d   = k_q + AW'(1);
                if (k_q == AW'(TAPS-1)) begin
                    state_d = IDLE;
                    y_d     = y_red;
                    ov_d    = 1'b1;
`ifdef FIR_SAT_EN
                    sat_d   = sat_now;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            wp_q    <= '0;
            base_q  <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            ov_q    <= 1'b0;
`ifdef FIR_SAT_EN
            sat_q   <= 1'b0;
`endif
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
                hist_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wp_q    <= wp_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            ov_q    <= ov_d;
`ifdef FIR_SAT_EN
            sat_q   <= sat_d;
`endif
            coef_q  <= coef_d;
            hist_q  <= hist_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == MAC);
    assign out_valid = ov_q;
    assign y         = y_q;
`ifdef FIR_SAT_EN
    assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_fir_serial_mac.sv
// Scoreboard bench for fir_serial_mac: a sum-of-products reference model queues expected results
// at each accept; a negedge monitor pops and compares on every out_valid.
module tb_fir_serial_mac;

    localparam int TAPS = 21;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  x;
    logic               coef_we;
    logic [4:0]         coef_addr;
    logic signed [7:0]  coef_data;
    logic               out_valid;
    logic signed [17:0] y;
    logic               busy;
`ifdef FIR_SAT_EN
    logic               sat_flag;
`endif

    fir_serial_mac dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .y(y),
`ifdef FIR_SAT_EN
        .sat_flag(sat_flag),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int y;
        bit sat;
        int acc_edge;
    } exp_t;

    exp_t sbq[$];
    int   cm[TAPS];
    int   hq[$];
    int   checks   = 0;
    int   failures = 0;
    bit   hold_mode = 0;
    int   last_acc  = -1;
    int   brun      = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: y[n] = sum c[k]*x[n-k], missing history = 0, then reduce to 18 bits.
    function automatic void model_accept(int xv, int acc_edge);
        longint s = 0;
        exp_t   e;
        hq.push_front(xv);
        if (hq.size() > TAPS) void'(hq.pop_back());
        for (int k = 0; k < TAPS; k++)
            if (k < hq.size()) s += longint'(cm[k]) * longint'(hq[k]);
        e.sat = 1'b0;
`ifdef FIR_SAT_EN
        if (s > 131071)       begin e.y = 131071;  e.sat = 1'b1; end
        else if (s < -131072) begin e.y = -131072; e.sat = 1'b1; end
        else                        e.y = int'(s);
`else
        s = s & 64'h3FFFF;
        if (s >= 131072) s -= 262144;
        e.y = int'(s);
`endif
        e.acc_edge = acc_edge;
        sbq.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            brun = 0;
        end else begin
            chk("busy_vs_ready", int'(busy), int'(!in_ready));
            if (busy) brun++;
            else begin
                if (brun != 0) chk("busy_len", brun, TAPS);
                brun = 0;
            end
            if (out_valid) begin
                if (sbq.size() == 0) chk("unexpected_out", int'(out_valid), 0);
                else begin
                    e = sbq.pop_front();
                    chk("y", int'(y), e.y);
                    chk("latency", cyc - e.acc_edge, TAPS);
`ifdef FIR_SAT_EN
                    chk("sat_flag", int'(sat_flag), int'(e.sat));
`endif
                end
            end
        end
    end

    task automatic wcoef(int a, int d);
        coef_we   = 1'b1;
        coef_addr = 5'(a);
        coef_data = 8'(d);
        if (in_ready && a < TAPS) cm[a] = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic send(int xv, bit we = 0, int a = 0, int d = 0);
        int g = 0;
        in_valid = 1'b1;
        x        = 8'(xv);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            chk("accept_timeout", int'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        if (we) begin
            coef_we   = 1'b1;
            coef_addr = 5'(a);
            coef_data = 8'(d);
            if (a < TAPS) cm[a] = d;
        end
        model_accept(xv, cyc + 1);
        if (hold_mode && last_acc >= 0) chk("accept_spacing", cyc + 1 - last_acc, TAPS + 1);
        last_acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((sbq.size() != 0 || !in_ready) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (sbq.size() != 0) chk("drain", sbq.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        #1;
        chk("rst_y", int'(y), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        foreach (cm[i]) cm[i] = 0;
        hq.delete();
        sbq.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic impulse();
        for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
        send(1);
        for (int i = 0; i < 24; i++) send(0);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; x = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        repeat (2) @(negedge clk);
        chk("init_y", int'(y), 0);
        chk("init_in_ready", int'(in_ready), 1);
        chk("init_busy", int'(busy), 0);
        chk("init_out_valid", int'(out_valid), 0);
        #2 rst = 1'b0;
        @(negedge clk);

        // Impulse response: 1..21 then zeros
        impulse();

        // Full-scale positive accumulation (wrap or saturate)
        do_reset();
        for (int k = 0; k < TAPS; k++) wcoef(k, 127);
        for (int i = 0; i < TAPS; i++) send(127);
        drain();

        // Negative full scale
        do_reset();
        wcoef(0, -128);
        send(-128);
        send(5);
        drain();

        // Continuous in_valid: accept spacing TAPS+1
        hold_mode = 1'b1;
        last_acc  = -1;
        for (int i = 0; i < 6; i++) send(int'($urandom_range(0, 255)) - 128);
        hold_mode = 1'b0;
        drain();

        // Coefficient write rules
        do_reset();
        send(2);
        wcoef(0, 9);
        send(2, 1'b1, 0, 9);
        drain();
        wcoef(25, 77);
        send(1);
        drain();

        // Reset mid-sequence, then the impulse test must repeat exactly
        do_reset();
        for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
        send(1);
        repeat (10) @(negedge clk);
        do_reset();
        impulse();

        // Randomized traffic with coefficient writes, some while busy or out of range
        do_reset();
        for (int k = 0; k < TAPS; k++) wcoef(k, int'($urandom_range(0, 255)) - 128);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                wcoef(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)) - 128);
            if ($urandom_range(0, 4) == 0)
                send(int'($urandom_range(0, 255)) - 128, 1'b1, int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 255)) - 128);
            else
                send(int'($urandom_range(0, 255)) - 128);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
